// File: rtl/multi_led_blinker_if.sv
// Configuration write port of the multi-channel LED blinker.
// The board control logic drives the master side; the blinker is the slave.
interface multi_led_blinker_if #(
   parameter int CH_NUM = 4,
   parameter int PER_W  = 12,
   parameter int CNT_W  = 4
);
   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [1:0]       cfg_mode;
   logic [PER_W-1:0] cfg_half;
   logic [CNT_W-1:0] cfg_count;

   modport master (
      output cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_mode, cfg_half, cfg_count,
      output cfg_ready
   );
endinterface

// File: rtl/multi_led_blinker.sv
// N-channel LED driver: shared tick prescaler, per-channel OFF/ON/BLINK/PULSE
// mode controller, configured through a valid/ready write port.
module multi_led_blinker #(
   parameter int TICK_DIV = 50000,
   parameter int CH_NUM   = 4,
   parameter int PER_W    = 12,
   parameter int CNT_W    = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   multi_led_blinker_if.slave     cfg,
   output logic [CH_NUM-1:0]      led,
   output logic [CH_NUM-1:0]      busy
);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PULSE = 2'd3
   } mode_e;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;
   logic             wr_en;
   logic [PER_W-1:0] half_sat;

   mode_e            mode_q   [CH_NUM];
   mode_e            mode_d   [CH_NUM];
   logic [PER_W-1:0] half_q   [CH_NUM];
   logic [PER_W-1:0] half_d   [CH_NUM];
   logic [PER_W-1:0] phase_q  [CH_NUM];
   logic [PER_W-1:0] phase_d  [CH_NUM];
   logic [CNT_W-1:0] remain_q [CH_NUM];
   logic [CNT_W-1:0] remain_d [CH_NUM];
   logic [CH_NUM-1:0] led_q, led_d;
   logic [CH_NUM-1:0] busy_q, busy_d;

   assign tick          = (pre_q == PRE_W'(TICK_DIV - 1));
   assign pre_d         = tick ? '0 : pre_q + PRE_W'(1);
   assign cfg.cfg_ready = ~rstn;
   assign wr_en         = cfg.cfg_valid & cfg.cfg_ready;
   assign half_sat      = (cfg.cfg_half == '0) ? PER_W'(1) : cfg.cfg_half;

   // A write to a channel wins over that channel's tick; out-of-range
   // channel numbers never match any c and are silently dropped.
   always_comb begin
      mode_d   = mode_q;
      half_d   = half_q;
      phase_d  = phase_q;
      remain_d = remain_q;
      led_d    = led_q;
      busy_d   = busy_q;
      for (int c = 0; c < CH_NUM; c++) begin
         if (wr_en && (int'(cfg.cfg_ch) == c)) begin
            case (mode_e'(cfg.cfg_mode))
               MODE_OFF: begin
                  mode_d[c] = MODE_OFF;
                  led_d[c]  = 1'b0;
                  busy_d[c] = 1'b0;
               end
               MODE_ON: begin
                  mode_d[c] = MODE_ON;
                  led_d[c]  = 1'b1;
                  busy_d[c] = 1'b0;
               end
               MODE_BLINK: begin
                  mode_d[c]  = MODE_BLINK;
                  led_d[c]   = 1'b1;
                  busy_d[c]  = 1'b0;
                  phase_d[c] = '0;
                  half_d[c]  = half_sat;
               end
               MODE_PULSE: begin
                  if (cfg.cfg_count == '0) begin
                     mode_d[c] = MODE_OFF;
                     led_d[c]  = 1'b0;
                     busy_d[c] = 1'b0;
                  end else begin
                     mode_d[c]   = MODE_PULSE;
                     led_d[c]    = 1'b1;
                     busy_d[c]   = 1'b1;
                     phase_d[c]  = '0;
                     remain_d[c] = cfg.cfg_count;
                     half_d[c]   = half_sat;
                  end
               end
               default: ;
            endcase
         end else if (tick && (mode_q[c] == MODE_BLINK || mode_q[c] == MODE_PULSE)) begin
            if (phase_q[c] == half_q[c] - PER_W'(1)) begin
               phase_d[c] = '0;
               if (mode_q[c] == MODE_PULSE && led_q[c]) begin
                  // Falling edge of a pulse: the last one stops the channel outright.
                  led_d[c] = 1'b0;
                  if (remain_q[c] == CNT_W'(1)) begin
                     mode_d[c] = MODE_OFF;
                     busy_d[c] = 1'b0;
                  end else begin
                     remain_d[c] = remain_q[c] - CNT_W'(1);
                  end
               end else begin
                  led_d[c] = ~led_q[c];
               end
            end else begin
               phase_d[c] = phase_q[c] + PER_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         pre_q  <= '0;
         led_q  <= '0;
         busy_q <= '0;
         for (int c = 0; c < CH_NUM; c++) begin
            mode_q[c]   <= MODE_OFF;
            half_q[c]   <= '0;
            phase_q[c]  <= '0;
            remain_q[c] <= '0;
         end
      end else begin
         pre_q    <= pre_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         mode_q   <= mode_d;
         half_q   <= half_d;
         phase_q  <= phase_d;
         remain_q <= remain_d;
      end
   end

   assign led  = led_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench for multi_led_blinker with small tick divider; a second
// 5-channel instance exercises a write to a channel number beyond CH_NUM.
module tb_multi_led_blinker;
   localparam int TD = 4;
   localparam int CN = 4;
   localparam int PW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [CN-1:0] led, busy;
   logic [4:0]    led2, busy2;
   int            checks   = 0;
   int            failures = 0;
   int            tb_pre   = 0;

   always #5 clk = ~clk;

   multi_led_blinker_if #(.CH_NUM(CN), .PER_W(PW), .CNT_W(CW)) cif ();
   multi_led_blinker_if #(.CH_NUM(5),  .PER_W(PW), .CNT_W(CW)) cif2 ();

   multi_led_blinker #(.TICK_DIV(TD), .CH_NUM(CN), .PER_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .cfg(cif), .led(led), .busy(busy)
   );

   multi_led_blinker #(.TICK_DIV(TD), .CH_NUM(5), .PER_W(PW), .CNT_W(CW)) dut2 (
      .clk(clk), .rstn(rstn), .cfg(cif2), .led(led2), .busy(busy2)
   );

   // Reference prescaler position, so writes can be placed relative to ticks.
   always @(posedge clk) tb_pre <= rstn ? 0 : ((tb_pre == TD - 1) ? 0 : tb_pre + 1);

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input int ch, input int mode, input int half, input int cnt);
      cif.cfg_valid = 1'b1;
      cif.cfg_ch    = 2'(ch);
      cif.cfg_mode  = 2'(mode);
      cif.cfg_half  = 4'(half);
      cif.cfg_count = 4'(cnt);
      step();
      cif.cfg_valid = 1'b0;
   endtask

   task automatic to_pre(input int n);
      for (int i = 0; i < TD && tb_pre != n; i++) step();
   endtask

   initial begin
      int e0, e3, e, b;
      rstn = 1'b1;
      cif.cfg_valid  = 1'b0; cif.cfg_ch  = '0; cif.cfg_mode  = '0; cif.cfg_half  = '0; cif.cfg_count  = '0;
      cif2.cfg_valid = 1'b0; cif2.cfg_ch = '0; cif2.cfg_mode = '0; cif2.cfg_half = '0; cif2.cfg_count = '0;

      repeat (3) begin
         step();
         check_val("rst_led", led, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_ready", cif.cfg_ready, 0);
      end
      rstn = 1'b0;
      #1 check_val("ready_release", cif.cfg_ready, 1);

      // ON then OFF on channel 2
      wr(2, 1, 0, 0);
      check_val("on_led", led, 4'b0100);
      repeat (4) begin
         step();
         check_val("on_hold", led, 4'b0100);
      end
      wr(2, 0, 0, 0);
      check_val("off_led", led, 0);
      check_val("off_busy", busy, 0);

      // Out-of-range channel on the 5-channel instance
      cif2.cfg_valid = 1'b1; cif2.cfg_ch = 3'd0; cif2.cfg_mode = 2'd1;
      step();
      cif2.cfg_ch = 3'd5; cif2.cfg_mode = 2'd2; cif2.cfg_half = 4'd3;
      step();
      cif2.cfg_valid = 1'b0;
      check_val("oor_led", led2, 5'b00001);
      check_val("oor_busy", busy2, 0);
      repeat (2) step();
      check_val("oor_led_hold", led2, 5'b00001);

      // BLINK ch0 half=3, write the cycle before a tick; ch3 BLINK lands on a tick at j=69
      to_pre(2);
      wr(0, 2, 3, 0);
      check_val("blink_start", led, 4'b0001);
      for (int j = 1; j <= 80; j++) begin
         if (j == 69) begin
            cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd3; cif.cfg_mode = 2'd2; cif.cfg_half = 4'd2;
         end
         step();
         cif.cfg_valid = 1'b0;
         e0 = (j < 9) ? 1 : ((((j - 9) / 12) % 2 == 0) ? 0 : 1);
         e3 = (j >= 69 && j < 77) ? 1 : 0;
         check_val("blink_led", led, e0 | (e3 << 3));
      end
      check_val("blink_busy", busy, 0);
      wr(0, 0, 0, 0);
      wr(3, 0, 0, 0);
      check_val("blink_off", led, 0);

      // PULSE ch1 count=2 half=1, written on a tick cycle
      to_pre(TD - 1);
      wr(1, 3, 1, 2);
      check_val("pulse_led0", led, 4'b0010);
      check_val("pulse_busy0", busy, 4'b0010);
      for (int j = 1; j <= 20; j++) begin
         step();
         e = ((j < 4) || (j >= 8 && j < 12)) ? 1 : 0;
         b = (j < 12) ? 1 : 0;
         check_val("pulse_led", led, e << 1);
         check_val("pulse_busy", busy, b << 1);
      end

      // BLINK with half=0 behaves as half=1
      to_pre(TD - 1);
      wr(2, 2, 0, 0);
      check_val("half0_start", led, 4'b0100);
      for (int j = 1; j <= 12; j++) begin
         step();
         e = ((j / 4) % 2 == 0) ? 1 : 0;
         check_val("half0_led", led, e << 2);
      end
      wr(2, 0, 0, 0);

      // PULSE with count=0 acts as OFF
      wr(0, 1, 0, 0);
      check_val("cnt0_pre", led, 4'b0001);
      wr(0, 3, 5, 0);
      check_val("cnt0_led", led, 0);
      check_val("cnt0_busy", busy, 0);

      // Rewrite a running PULSE (count 3) with count 1 on a tick cycle
      to_pre(TD - 1);
      wr(1, 3, 1, 3);
      repeat (4) step();
      check_val("rw_mid_led", led, 0);
      check_val("rw_mid_busy", busy, 4'b0010);
      repeat (3) step();
      wr(1, 3, 1, 1);
      check_val("rw_led0", led, 4'b0010);
      check_val("rw_busy0", busy, 4'b0010);
      for (int j = 1; j <= 10; j++) begin
         step();
         e = (j < 4) ? 1 : 0;
         check_val("rw_led", led, e << 1);
         check_val("rw_busy", busy, e << 1);
      end

      // Reset in the middle of a PULSE, with a concurrent write
      to_pre(TD - 1);
      wr(1, 3, 2, 5);
      repeat (3) step();
      check_val("mrst_pre_led", led, 4'b0010);
      check_val("mrst_pre_busy", busy, 4'b0010);
      rstn = 1'b1;
      cif.cfg_valid = 1'b1; cif.cfg_ch = 2'd2; cif.cfg_mode = 2'd1;
      step();
      check_val("mrst_led", led, 0);
      check_val("mrst_busy", busy, 0);
      check_val("mrst_ready", cif.cfg_ready, 0);
      rstn = 1'b0;
      cif.cfg_valid = 1'b0;
      step();
      check_val("mrst_after_led", led, 0);
      check_val("mrst_after_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
